delay_line_fifo: RTL and testbench

//  Fixed-latency data delay line: every clock, i_data is shifted into a FIFO_LEN-deep register chain.
//  o_data is the sample captured FIFO_LEN clocks earlier.
//  o_valid marks that the chain has been completely filled since reset.

---
 rtl/delay_line_pkg.sv | 12 +
 rtl/delay_stage.sv | 18 +
 rtl/delay_line_fifo.sv | 69 ++++++
 tb/tb_delay_line_fifo.sv | 115 +++++++++++
 4 files changed

// File: rtl/delay_line_pkg.sv
// Shared sizing helpers and default parameters for the delay_line_fifo slice.
package delay_line_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_FIFO_LEN = 2;

  // The fill counter must be able to hold the value len itself, not just len-1.
  function automatic int cnt_width(int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/delay_stage.sv
// One register of the delay chain; clears to zero on the asynchronous active-low reset.
module delay_stage
  import delay_line_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else      q <= d;
  end

endmodule

// File: rtl/delay_line_fifo.sv
// Fixed-latency delay line: FIFO_LEN register stages plus a saturating fill counter for o_valid.
// Define DELAY_LINE_ASSERT_EN to compile in the SVA protocol checks.
module delay_line_fifo
  import delay_line_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int FIFO_LEN = DEF_FIFO_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  localparam int            CW   = cnt_width(FIFO_LEN);
  localparam logic [CW-1:0] FULL = CW'(FIFO_LEN);

  if (FIFO_LEN < 1) begin : g_bad_len
    $error("delay_line_fifo: FIFO_LEN must be at least 1");
  end

  logic [WIDTH-1:0] stage [FIFO_LEN];
  logic [CW-1:0]    valid_counter;

  for (genvar k = 0; k < FIFO_LEN; k++) begin : g_stage
    if (k == 0) begin : g_head
      delay_stage #(.WIDTH(WIDTH)) u_stage (
        .clk (clk),
        .rst (rst),
        .d   (i_data),
        .q   (stage[0])
      );
    end else begin : g_tail
      delay_stage #(.WIDTH(WIDTH)) u_stage (
        .clk (clk),
        .rst (rst),
        .d   (stage[k-1]),
        .q   (stage[k])
      );
    end
  end

  // Counts edges since reset and parks at FULL, so o_valid is sticky until the next reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     valid_counter <= '0;
    else if (valid_counter != FULL) valid_counter <= valid_counter + CW'(1);
  end

  assign o_data  = stage[FIFO_LEN-1];
  assign o_valid = (valid_counter == FULL);

`ifdef DELAY_LINE_ASSERT_EN
  always_comb begin
    if (!rst) a_valid_low_in_reset: assert (!o_valid);
  end

  a_cnt_bounded: assert property (@(posedge clk) valid_counter <= FULL);

  a_valid_sticky: assert property (@(posedge clk) disable iff (!rst)
    o_valid |=> o_valid);

  a_data_latency: assert property (@(posedge clk) disable iff (!rst)
    o_valid |-> (o_data == $past(i_data, FIFO_LEN)));
`else
  // Checks not compiled; datapath and counter are unaffected.
`endif

endmodule

// File: tb/tb_delay_line_fifo.sv
// Directed bench for delay_line_fifo at FIFO_LEN = 1, 2 and 4 driven from shared stimulus.
module tb_delay_line_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_data;
  logic [7:0] od1, od2, od4;
  logic       ov1, ov2, ov4;

  int checks = 0;
  int errors = 0;
  int m;

  always #5 clk = ~clk;

  delay_line_fifo #(.WIDTH(8), .FIFO_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .i_data(i_data), .o_data(od1), .o_valid(ov1));
  delay_line_fifo #(.WIDTH(8), .FIFO_LEN(2)) dut2 (
    .clk(clk), .rst(rst), .i_data(i_data), .o_data(od2), .o_valid(ov2));
  delay_line_fifo #(.WIDTH(8), .FIFO_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .i_data(i_data), .o_data(od4), .o_valid(ov4));

  // Reference: after the m-th edge since release, a ramp starting at base shows base+(m-L) once full.
  function automatic logic [7:0] exp_data(int edges, int len, logic [7:0] base);
    if (edges >= len) return base + 8'(edges - len);
    return 8'h00;
  endfunction

  function automatic int exp_cnt(int edges, int len);
    return (edges >= len) ? len : edges;
  endfunction

  task automatic test_reset();
    rst    = 1'b0;
    i_data = 8'hAA;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks += 9;
      if (od1 !== 8'h00) begin errors++; $display("FAIL reset_data L=1 got %h want 00", od1); end
      if (od2 !== 8'h00) begin errors++; $display("FAIL reset_data L=2 got %h want 00", od2); end
      if (od4 !== 8'h00) begin errors++; $display("FAIL reset_data L=4 got %h want 00", od4); end
      if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_valid L=1 got %b want 0", ov1); end
      if (ov2 !== 1'b0) begin errors++; $display("FAIL reset_valid L=2 got %b want 0", ov2); end
      if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_valid L=4 got %b want 0", ov4); end
      if (int'(dut1.valid_counter) !== 0) begin errors++; $display("FAIL reset_cnt L=1 got %0d want 0", dut1.valid_counter); end
      if (int'(dut2.valid_counter) !== 0) begin errors++; $display("FAIL reset_cnt L=2 got %0d want 0", dut2.valid_counter); end
      if (int'(dut4.valid_counter) !== 0) begin errors++; $display("FAIL reset_cnt L=4 got %0d want 0", dut4.valid_counter); end
    end
  endtask

  task automatic test_ramp(input int first, input int last, input logic [7:0] base);
    for (int e = first; e <= last; e++) begin
      i_data = base + 8'(e - 1);
      @(posedge clk); #1;
      m = e;
      checks += 9;
      if (od1 !== exp_data(e, 1, base)) begin errors++; $display("FAIL ramp_data L=1 m=%0d got %h want %h", e, od1, exp_data(e, 1, base)); end
      if (od2 !== exp_data(e, 2, base)) begin errors++; $display("FAIL ramp_data L=2 m=%0d got %h want %h", e, od2, exp_data(e, 2, base)); end
      if (od4 !== exp_data(e, 4, base)) begin errors++; $display("FAIL ramp_data L=4 m=%0d got %h want %h", e, od4, exp_data(e, 4, base)); end
      if (ov1 !== (e >= 1)) begin errors++; $display("FAIL ramp_valid L=1 m=%0d got %b want %b", e, ov1, (e >= 1)); end
      if (ov2 !== (e >= 2)) begin errors++; $display("FAIL ramp_valid L=2 m=%0d got %b want %b", e, ov2, (e >= 2)); end
      if (ov4 !== (e >= 4)) begin errors++; $display("FAIL ramp_valid L=4 m=%0d got %b want %b", e, ov4, (e >= 4)); end
      if (int'(dut1.valid_counter) !== exp_cnt(e, 1)) begin errors++; $display("FAIL ramp_cnt L=1 m=%0d got %0d want %0d", e, dut1.valid_counter, exp_cnt(e, 1)); end
      if (int'(dut2.valid_counter) !== exp_cnt(e, 2)) begin errors++; $display("FAIL ramp_cnt L=2 m=%0d got %0d want %0d", e, dut2.valid_counter, exp_cnt(e, 2)); end
      if (int'(dut4.valid_counter) !== exp_cnt(e, 4)) begin errors++; $display("FAIL ramp_cnt L=4 m=%0d got %0d want %0d", e, dut4.valid_counter, exp_cnt(e, 4)); end
    end
  endtask

  task automatic test_fill_and_ramp();
    rst = 1'b1;
    test_ramp(1, 14, 8'h00);
  endtask

  task automatic test_saturation();
    // 300 edges after release in total; the ramp wraps through every byte value.
    test_ramp(15, 300, 8'h00);
  endtask

  task automatic test_mid_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    test_ramp(1, 7, 8'h00);
    #3;
    checks++;
    if (od2 !== 8'h05) begin errors++; $display("FAIL midrst_pre L=2 got %h want 05", od2); end
    rst = 1'b0;
    #1;
    checks += 9;
    if (od1 !== 8'h00) begin errors++; $display("FAIL midrst_data L=1 got %h want 00", od1); end
    if (od2 !== 8'h00) begin errors++; $display("FAIL midrst_data L=2 got %h want 00", od2); end
    if (od4 !== 8'h00) begin errors++; $display("FAIL midrst_data L=4 got %h want 00", od4); end
    if (ov1 !== 1'b0) begin errors++; $display("FAIL midrst_valid L=1 got %b want 0", ov1); end
    if (ov2 !== 1'b0) begin errors++; $display("FAIL midrst_valid L=2 got %b want 0", ov2); end
    if (ov4 !== 1'b0) begin errors++; $display("FAIL midrst_valid L=4 got %b want 0", ov4); end
    if (int'(dut1.valid_counter) !== 0) begin errors++; $display("FAIL midrst_cnt L=1 got %0d want 0", dut1.valid_counter); end
    if (int'(dut2.valid_counter) !== 0) begin errors++; $display("FAIL midrst_cnt L=2 got %0d want 0", dut2.valid_counter); end
    if (int'(dut4.valid_counter) !== 0) begin errors++; $display("FAIL midrst_cnt L=4 got %0d want 0", dut4.valid_counter); end
    @(posedge clk); #1;
    rst = 1'b1;
    test_ramp(1, 8, 8'hA0);
  endtask

  initial begin
    rst    = 1'b0;
    i_data = 8'hAA;
    test_reset();
    test_fill_and_ramp();
    test_saturation();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
